// File: rtl/logicfunc_sweep_ctrl_jdl25175.sv
// Truth-table sweep sequencer for two 4-input logic-function implementations.
// Walks abcd through 0..15, holds each vector for HOLD_CYCLES settle cycles,
// then samples f_a/f_b and records both truth tables and their differences.
`timescale 1ns/1ps

module logicfunc_sweep_ctrl_jdl25175 #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        f_a,
    input  logic        f_b,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_a,
    output logic [15:0] truth_b,
    output logic        mismatch,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_bad,
    output logic        first_bad_valid
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

    state_e     state_q;
    logic [7:0] hold_cnt_q;

    // Sweep FSM with all outputs registered; reset and abort both land in idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            hold_cnt_q      <= '0;
            abcd            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            truth_a         <= '0;
            truth_b         <= '0;
            mismatch        <= 1'b0;
            mismatch_count  <= '0;
            first_bad       <= '0;
            first_bad_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    abcd <= '0;
                    if (start && !abort) begin
                        truth_a         <= '0;
                        truth_b         <= '0;
                        mismatch        <= 1'b0;
                        mismatch_count  <= '0;
                        first_bad       <= '0;
                        first_bad_valid <= 1'b0;
                        hold_cnt_q      <= '0;
                        busy            <= 1'b1;
                        state_q         <= StSettle;
                    end
                end
                StSettle: begin
                    if (abort) begin
                        hold_cnt_q <= '0;
                        abcd       <= '0;
                        busy       <= 1'b0;
                        state_q    <= StIdle;
                    end else if (hold_cnt_q == HoldLast) begin
                        hold_cnt_q <= '0;
                        state_q    <= StSample;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                StSample: begin
                    if (abort) begin
                        // Capture of the current vector is dropped on abort.
                        abcd    <= '0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        truth_a[abcd] <= f_a;
                        truth_b[abcd] <= f_b;
                        if (f_a != f_b) begin
                            mismatch       <= 1'b1;
                            mismatch_count <= mismatch_count + 5'd1;
                            if (!first_bad_valid) begin
                                first_bad       <= abcd;
                                first_bad_valid <= 1'b1;
                            end
                        end
                        if (abcd == 4'd15) begin
                            // abcd is left at 15 through the done cycle.
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            abcd    <= abcd + 4'd1;
                            state_q <= StSettle;
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    abcd    <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    abcd    <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
